// File: rtl/ram_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-ported RAM with fixed read latency.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 1 has fixed priority.
module ram_arbiter #(
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [3:0] WAIT_LOAD = 4'(RD_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        gnt;
   logic        wr;
   logic        any_req;
   logic        pick1;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic        misaligned;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic        last;
`endif

   always_comb begin
      any_req = m0_req | m1_req;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      // On contention the port that was not granted last wins.
      pick1 = m1_req & (~m0_req | ~last);
`else
      pick1 = m1_req;
`endif
      sel_addr   = pick1 ? m1_addr : m0_addr;
      sel_we     = pick1 & m1_we;
      misaligned = (sel_addr[1:0] != 2'b00);
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         gnt       <= 1'b0;
         wr        <= 1'b0;
         mem_addr  <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         m0_ack    <= 1'b0;
         m0_rdata  <= '0;
         m0_err    <= 1'b0;
         m1_ack    <= 1'b0;
         m1_rdata  <= '0;
         m1_err    <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last      <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt <= pick1;
                  wr  <= sel_we;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                  last <= pick1;
`endif
                  if (misaligned) begin
                     // Error completes without ever touching the RAM.
                     state  <= DONE;
                     m0_ack <= ~pick1;
                     m0_err <= ~pick1;
                     m1_ack <= pick1;
                     m1_err <= pick1;
                  end else begin
                     state     <= ACCESS;
                     mem_addr  <= sel_addr;
                     mem_wdata <= pick1 ? m1_wdata : '0;
                     mem_we    <= sel_we;
                     mem_re    <= ~sel_we;
                  end
               end
            end
            ACCESS: begin
               if (wr) begin
                  state  <= DONE;
                  mem_we <= 1'b0;
                  m0_ack <= ~gnt;
                  m1_ack <= gnt;
               end else begin
                  state <= WAIT;
                  cnt   <= WAIT_LOAD;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state    <= DONE;
                  mem_re   <= 1'b0;
                  m0_ack   <= ~gnt;
                  m1_ack   <= gnt;
                  m0_rdata <= gnt ? '0 : mem_rdata;
                  m1_rdata <= gnt ? mem_rdata : '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               state    <= IDLE;
               m0_ack   <= 1'b0;
               m0_err   <= 1'b0;
               m0_rdata <= '0;
               m1_ack   <= 1'b0;
               m1_err   <= 1'b0;
               m1_rdata <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
